// File: rtl/id_stage_hs_if.sv
// Decode-stage bundle: IF->ID handshake, ID->EX handshake, two register-file
// read ports and the EX hazard snoop. "slave" is the decode stage's view;
// "master" is the surrounding pipeline (IF, EX, register file).
interface id_stage_hs_if #(
  parameter int WIDTH        = 32,
  parameter int PC_W         = 30,
  parameter int REG_ADDR_LEN = 5
);
  // IF side
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             in_ir;
  logic [PC_W-1:0]         in_pc;
  // EX side
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_ir;
  logic [PC_W-1:0]         out_pc;
  logic [WIDTH-1:0]        out_x;
  logic [WIDTH-1:0]        out_y;
  logic [REG_ADDR_LEN-1:0] out_dst;
  logic                    out_load;
  // register file read ports
  logic [REG_ADDR_LEN-1:0] rd1_addr;
  logic                    rd1_en;
  logic [WIDTH-1:0]        rd1_data;
  logic                    rd1_st;
  logic [REG_ADDR_LEN-1:0] rd2_addr;
  logic                    rd2_en;
  logic [WIDTH-1:0]        rd2_data;
  logic                    rd2_st;
  // EX occupancy snoop for the load-use interlock
  logic                    ex_valid;
  logic                    ex_load;
  logic [REG_ADDR_LEN-1:0] ex_dst;

  modport master (
    output in_valid, in_ir, in_pc, out_ready,
           rd1_data, rd1_st, rd2_data, rd2_st,
           ex_valid, ex_load, ex_dst,
    input  in_ready, out_valid, out_ir, out_pc, out_x, out_y, out_dst, out_load,
           rd1_addr, rd1_en, rd2_addr, rd2_en
  );

  modport slave (
    input  in_valid, in_ir, in_pc, out_ready,
           rd1_data, rd1_st, rd2_data, rd2_st,
           ex_valid, ex_load, ex_dst,
    output in_ready, out_valid, out_ir, out_pc, out_x, out_y, out_dst, out_load,
           rd1_addr, rd1_en, rd2_addr, rd2_en
  );
endinterface

// File: rtl/id_stage_hs.sv
// Decode stage: decodes an instruction, fetches up to two operands via strobed
//   read ports, and holds the result for EX. Latency: 1 cycle with no reads,
//   2+ with reads. Backpressure: in_ready only when empty or EX takes the result.
// Ports: clk, rst (sync, active-high), flush; bus (slave) carries IF/EX
//   handshakes, rd1/rd2 request/strobe ports and the EX load snoop.
module id_stage_hs #(
  parameter int          WIDTH        = 32,
  parameter int          PC_W         = 30,
  parameter int          REG_ADDR_LEN = 5,
  parameter bit          ZERO_REG     = 1'b1,
  parameter logic [31:0] NOP_WORD     = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  id_stage_hs_if.slave  bus
);

  // Opcode map (ir[31:26]). I-type ALU ops occupy 0x08-0x0F, branches 0x18-0x1B;
  // NOP (0x00), HALT (0x3F) and anything unlisted decode to "no operands".
  localparam logic [5:0] OP_R   = 6'h01;
  localparam logic [5:0] OP_LW  = 6'h10;
  localparam logic [5:0] OP_LH  = 6'h11;
  localparam logic [5:0] OP_LD  = 6'h12;
  localparam logic [5:0] OP_SW  = 6'h14;
  localparam logic [5:0] OP_SH  = 6'h15;
  localparam logic [5:0] OP_SD  = 6'h16;
  localparam logic [5:0] OP_J   = 6'h20;
  localparam logic [5:0] OP_JAL = 6'h21;

  typedef enum logic [1:0] {EMPTY, READ, FULL} state_t;

  typedef struct packed {
    logic                    use1;
    logic                    use2;
    logic [REG_ADDR_LEN-1:0] a1;
    logic [REG_ADDR_LEN-1:0] a2;
    logic [REG_ADDR_LEN-1:0] dst;
    logic [WIDTH-1:0]        x;
    logic [WIDTH-1:0]        y;
    logic                    load;
  } dec_t;

  state_t                  state, state_nxt;
  dec_t                    dec;
  logic [5:0]              op;
  logic [REG_ADDR_LEN-1:0] f_rd, f_rs, f_rt;
  logic [WIDTH-1:0]        imm_sx, tgt_zx;

  logic [31:0]             ir_q;
  logic [PC_W-1:0]         pc_q;
  logic [WIDTH-1:0]        x_q, y_q;
  logic [REG_ADDR_LEN-1:0] dst_q, a1_q, a2_q;
  logic                    load_q, pend1, pend2;
  logic                    haz1, haz2, cap1, cap2, accept;

  // Instruction decode straight off the IF bus so it is ready at accept.
  always_comb begin
    op     = bus.in_ir[31:26];
    f_rd   = REG_ADDR_LEN'(bus.in_ir[25:21]);
    f_rs   = REG_ADDR_LEN'(bus.in_ir[20:16]);
    f_rt   = REG_ADDR_LEN'(bus.in_ir[15:11]);
    imm_sx = {{(WIDTH-16){bus.in_ir[15]}}, bus.in_ir[15:0]};
    tgt_zx = {{(WIDTH-26){1'b0}}, bus.in_ir[25:0]};
    dec    = '0;
    casez (op)
      OP_R:                begin dec.use1 = 1'b1; dec.a1 = f_rs;
                                 dec.use2 = 1'b1; dec.a2 = f_rt; dec.dst = f_rd; end
      6'b001???:           begin dec.use1 = 1'b1; dec.a1 = f_rs;
                                 dec.y = imm_sx; dec.dst = f_rd; end
      OP_LW, OP_LH, OP_LD: begin dec.use1 = 1'b1; dec.a1 = f_rs;
                                 dec.y = imm_sx; dec.dst = f_rd; dec.load = 1'b1; end
      OP_SW, OP_SH, OP_SD: begin dec.use1 = 1'b1; dec.a1 = f_rd;
                                 dec.use2 = 1'b1; dec.a2 = f_rs; end
      6'b0110??:           begin dec.use1 = 1'b1; dec.a1 = f_rd; dec.y = imm_sx; end
      OP_J, OP_JAL:        dec.x = tgt_zx;
      default:             ;
    endcase
    // R0 is hardwired: skip the port, the operand field already holds 0.
    if (ZERO_REG) begin
      if (dec.a1 == '0) dec.use1 = 1'b0;
      if (dec.a2 == '0) dec.use2 = 1'b0;
    end
  end

  // A load sitting in EX whose result we still need blocks that port only.
  assign haz1 = bus.ex_valid && bus.ex_load && (bus.ex_dst != '0) && (bus.ex_dst == a1_q);
  assign haz2 = bus.ex_valid && bus.ex_load && (bus.ex_dst != '0) && (bus.ex_dst == a2_q);
  assign cap1 = bus.rd1_en && bus.rd1_st;
  assign cap2 = bus.rd2_en && bus.rd2_st;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = (state == EMPTY) || ((state == FULL) && bus.out_ready);
    bus.out_valid = (state == FULL);
    bus.rd1_en    = (state == READ) && pend1 && !haz1;
    bus.rd2_en    = (state == READ) && pend2 && !haz2;
    accept        = bus.in_valid && bus.in_ready && !flush;
    case (state)
      EMPTY: if (accept) state_nxt = (dec.use1 || dec.use2) ? READ : FULL;
      READ:  if ((!pend1 || cap1) && (!pend2 || cap2)) state_nxt = FULL;
      FULL:  if (bus.out_ready)
               state_nxt = !accept ? EMPTY : ((dec.use1 || dec.use2) ? READ : FULL);
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // Accept and capture are exclusive: accept happens only in EMPTY/FULL,
  // captures only in READ.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ir_q   <= NOP_WORD;
      pc_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      dst_q  <= '0;
      load_q <= 1'b0;
      a1_q   <= '0;
      a2_q   <= '0;
      pend1  <= 1'b0;
      pend2  <= 1'b0;
    end else if (accept) begin
      ir_q   <= bus.in_ir;
      pc_q   <= bus.in_pc;
      x_q    <= dec.x;
      y_q    <= dec.y;
      dst_q  <= dec.dst;
      load_q <= dec.load;
      a1_q   <= dec.a1;
      a2_q   <= dec.a2;
      pend1  <= dec.use1;
      pend2  <= dec.use2;
    end else begin
      if (cap1) begin
        x_q   <= bus.rd1_data;
        pend1 <= 1'b0;
      end
      if (cap2) begin
        y_q   <= bus.rd2_data;
        pend2 <= 1'b0;
      end
    end
  end

  assign bus.out_ir   = ir_q;
  assign bus.out_pc   = pc_q;
  assign bus.out_x    = x_q;
  assign bus.out_y    = y_q;
  assign bus.out_dst  = dst_q;
  assign bus.out_load = load_q;
  assign bus.rd1_addr = a1_q;
  assign bus.rd2_addr = a2_q;

endmodule

// File: tb/tb_id_stage_hs.sv
// Bench for id_stage_hs: directed scenarios plus a randomized run scored
//   against a behavioural decode model; register file modelled as an array
//   behind a strobe responder that can delay, withhold or spuriously strobe.
module tb_id_stage_hs;
  localparam int          WIDTH = 32;
  localparam int          PC_W  = 30;
  localparam int          AW    = 5;
  localparam logic [31:0] NOP   = 32'h0000_5A5A;

  logic clk = 1'b0;
  logic rst, flush;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   resp_mode = 0;  // 0: strobe on request, 1: random delay, 2: never
  bit   spur = 1'b0;    // junk strobes while a port is not requesting
  logic [WIDTH-1:0] regs [32];

  id_stage_hs_if #(.WIDTH(WIDTH), .PC_W(PC_W), .REG_ADDR_LEN(AW)) bus ();
  id_stage_hs #(.WIDTH(WIDTH), .PC_W(PC_W), .REG_ADDR_LEN(AW),
                .ZERO_REG(1'b1), .NOP_WORD(NOP))
    dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Register file responder
  initial begin
    bus.rd1_st = 1'b0; bus.rd2_st = 1'b0; bus.rd1_data = '0; bus.rd2_data = '0;
    forever begin
      @(negedge clk);
      if (bus.rd1_en && (resp_mode == 0 || (resp_mode == 1 && $urandom_range(0, 1) == 1))) begin
        bus.rd1_st = 1'b1; bus.rd1_data = regs[bus.rd1_addr];
      end else begin
        bus.rd1_st = !bus.rd1_en && spur && ($urandom_range(0, 1) == 1);
        bus.rd1_data = regs[bus.rd1_addr] ^ 32'h0BAD_F00D;
      end
      if (bus.rd2_en && (resp_mode == 0 || (resp_mode == 1 && $urandom_range(0, 1) == 1))) begin
        bus.rd2_st = 1'b1; bus.rd2_data = regs[bus.rd2_addr];
      end else begin
        bus.rd2_st = !bus.rd2_en && spur && ($urandom_range(0, 1) == 1);
        bus.rd2_data = regs[bus.rd2_addr] ^ 32'h0BAD_F00D;
      end
    end
  end

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rd, rs, rt);
    return {op, rd, rs, rt, 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd, rs,
                                       input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [WIDTH-1:0] rval(input logic [4:0] a);
    return (a == 5'd0) ? '0 : regs[a];
  endfunction

  // Reference decode from the instruction-class table.
  function automatic void model(input logic [31:0] ir, output logic [WIDTH-1:0] x, y,
                                output logic [4:0] dst, output logic ld, output int nrd);
    int op;
    longint v;
    logic [4:0] rd, rs, rt;
    logic [WIDTH-1:0] imm_s;
    op = int'(ir[31:26]); rd = ir[25:21]; rs = ir[20:16]; rt = ir[15:11];
    v = longint'(ir[15:0]);
    if (v >= 32768) v = v - 65536;
    imm_s = WIDTH'(v);
    x = '0; y = '0; dst = 5'd0; ld = 1'b0; nrd = 0;
    if (op == 1) begin
      x = rval(rs); y = rval(rt); dst = rd; nrd = int'(rs != 0) + int'(rt != 0);
    end else if (op >= 8 && op <= 15) begin
      x = rval(rs); y = imm_s; dst = rd; nrd = int'(rs != 0);
    end else if (op >= 16 && op <= 18) begin
      x = rval(rs); y = imm_s; dst = rd; ld = 1'b1; nrd = int'(rs != 0);
    end else if (op >= 20 && op <= 22) begin
      x = rval(rd); y = rval(rs); nrd = int'(rd != 0) + int'(rs != 0);
    end else if (op >= 24 && op <= 27) begin
      x = rval(rd); y = imm_s; nrd = int'(rd != 0);
    end else if (op == 32 || op == 33) begin
      x = WIDTH'(ir[25:0]);
    end
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [5:0] ops [16] = '{6'h00, 6'h01, 6'h01, 6'h08, 6'h0B, 6'h10, 6'h11, 6'h12,
                             6'h14, 6'h15, 6'h16, 6'h18, 6'h1B, 6'h20, 6'h21, 6'h3F};
    logic [31:0] ir;
    ir = $urandom;
    ir[31:26] = ops[$urandom_range(0, 15)];
    ir[25:21] = 5'($urandom_range(0, 7));
    ir[20:16] = 5'($urandom_range(0, 7));
    ir[15:11] = 5'($urandom_range(0, 7));
    return ir;
  endfunction

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_ir = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_load = 1'b0; bus.ex_dst = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Presents one instruction, returns cycles from accept to out_valid (-1 on timeout).
  // Returns positioned at the negedge of the first out_valid cycle, out_ready low.
  task automatic send(input logic [31:0] ir, input logic [PC_W-1:0] pc, output int lat);
    int guard;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_ir = ir; bus.in_pc = pc;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic pop();
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++; if ({bus.rd1_en, bus.rd2_en} !== 2'b00) begin n_fail++; $display("FAIL reset_rd_en got %b want 00", {bus.rd1_en, bus.rd2_en}); end
    n_checks++; if (bus.out_ir !== NOP) begin n_fail++; $display("FAIL reset_out_ir got %h want %h", bus.out_ir, NOP); end
    n_checks++; if ({bus.out_x, bus.out_y, bus.out_pc, bus.out_dst, bus.out_load} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got x=%h y=%h pc=%h dst=%0d ld=%b want all 0",
                         bus.out_x, bus.out_y, bus.out_pc, bus.out_dst, bus.out_load); end
  endtask

  task automatic test_rtype();
    int lat;
    resp_mode = 0; spur = 1'b0;
    send(mk_r(6'h01, 5'd7, 5'd3, 5'd4), 30'h123, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rtype_latency got %0d want 2", lat); end
    n_checks++; if (bus.out_x !== 32'h11) begin n_fail++; $display("FAIL rtype_x got %h want 11", bus.out_x); end
    n_checks++; if (bus.out_y !== 32'h22) begin n_fail++; $display("FAIL rtype_y got %h want 22", bus.out_y); end
    n_checks++; if (bus.out_dst !== 5'd7 || bus.out_load !== 1'b0) begin n_fail++; $display("FAIL rtype_dst got %0d/%b want 7/0", bus.out_dst, bus.out_load); end
    n_checks++; if (bus.out_pc !== 30'h123) begin n_fail++; $display("FAIL rtype_pc got %h want 123", bus.out_pc); end
    pop();
  endtask

  task automatic test_load_sext();
    int lat;
    resp_mode = 0; spur = 1'b1;
    send(mk_i(6'h10, 5'd6, 5'd5, 16'hFFFC), 30'h40, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency got %0d want 2", lat); end
    n_checks++; if (bus.out_y !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL lw_sext got %h want fffffffc", bus.out_y); end
    n_checks++; if (bus.out_x !== regs[5]) begin n_fail++; $display("FAIL lw_x got %h want %h", bus.out_x, regs[5]); end
    n_checks++; if (bus.out_load !== 1'b1 || bus.out_dst !== 5'd6) begin n_fail++; $display("FAIL lw_load got %b/%0d want 1/6", bus.out_load, bus.out_dst); end
    pop();
  endtask

  task automatic test_jump();
    int lat;
    resp_mode = 0; spur = 1'b1;
    send({6'h20, 26'h0000040}, 30'h80, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL jump_latency got %0d want 1", lat); end
    n_checks++; if (bus.out_x !== 32'h40 || bus.out_y !== 32'h0) begin n_fail++; $display("FAIL jump_xy got %h/%h want 40/0", bus.out_x, bus.out_y); end
    n_checks++; if ({bus.rd1_en, bus.rd2_en, bus.out_dst} !== '0) begin n_fail++; $display("FAIL jump_noread got en=%b%b dst=%0d want 00/0", bus.rd1_en, bus.rd2_en, bus.out_dst); end
    pop();
  endtask

  task automatic test_decode_table();
    logic [31:0] tbl [10];
    logic [WIDTH-1:0] ex_x, ex_y;
    logic [4:0] ex_d;
    logic ex_l;
    int nrd, lat;
    tbl = '{mk_i(6'h18, 5'd9, 5'd0, 16'h8001), mk_r(6'h14, 5'd10, 5'd11, 5'd0),
            mk_r(6'h01, 5'd5, 5'd0, 5'd12),    mk_r(6'h01, 5'd5, 5'd0, 5'd0),
            mk_i(6'h08, 5'd13, 5'd14, 16'h7FFF), mk_i(6'h11, 5'd1, 5'd0, 16'h8000),
            {6'h21, 26'h3FF_FFFF},             32'hFC00_1234,
            32'hF800_FFFF,                     mk_r(6'h16, 5'd0, 5'd7, 5'd3)};
    resp_mode = 0; spur = 1'b1;
    for (int i = 0; i < 10; i++) begin
      model(tbl[i], ex_x, ex_y, ex_d, ex_l, nrd);
      send(tbl[i], 30'(i), lat);
      n_checks++; if (lat !== ((nrd == 0) ? 1 : 2)) begin n_fail++; $display("FAIL table%0d_latency got %0d want %0d", i, lat, (nrd == 0) ? 1 : 2); end
      n_checks++; if (bus.out_x !== ex_x || bus.out_y !== ex_y) begin n_fail++; $display("FAIL table%0d_xy got %h/%h want %h/%h", i, bus.out_x, bus.out_y, ex_x, ex_y); end
      n_checks++; if (bus.out_dst !== ex_d || bus.out_load !== ex_l || bus.out_ir !== tbl[i]) begin
        n_fail++; $display("FAIL table%0d_ctl got dst=%0d ld=%b ir=%h want %0d/%b/%h", i, bus.out_dst, bus.out_load, bus.out_ir, ex_d, ex_l, tbl[i]); end
      pop();
    end
  endtask

  task automatic test_hazard();
    resp_mode = 0; spur = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_ir = mk_r(6'h01, 5'd8, 5'd2, 5'd4); bus.in_pc = 30'h55;
    bus.ex_valid = 1'b1; bus.ex_load = 1'b1; bus.ex_dst = 5'd2;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (bus.rd1_en !== 1'b0) begin n_fail++; $display("FAIL hazard_rd1_blocked cyc%0d got %b want 0", i, bus.rd1_en); end
      if (i == 0) begin
        n_checks++; if (bus.rd2_en !== 1'b1) begin n_fail++; $display("FAIL hazard_rd2_proceeds got %b want 1", bus.rd2_en); end
      end
      @(posedge clk); #1;
    end
    bus.ex_valid = 1'b0; bus.ex_load = 1'b0; bus.ex_dst = '0;
    @(negedge clk);
    n_checks++; if (bus.rd1_en !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hazard_release got en=%b vld=%b want 1/0", bus.rd1_en, bus.out_valid); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hazard_out_valid got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_x !== regs[2] || bus.out_y !== regs[4]) begin n_fail++; $display("FAIL hazard_xy got %h/%h want %h/%h", bus.out_x, bus.out_y, regs[2], regs[4]); end
    pop();
  endtask

  task automatic test_stall_b2b();
    logic [31:0] ir_a, ir_b;
    logic [WIDTH-1:0] ex_x, ex_y;
    logic [4:0] ex_d;
    logic ex_l;
    int nrd, lat;
    resp_mode = 0; spur = 1'b1;
    ir_a = mk_r(6'h14, 5'd12, 5'd13, 5'd0);
    ir_b = mk_r(6'h01, 5'd14, 5'd15, 5'd16);
    model(ir_a, ex_x, ex_y, ex_d, ex_l, nrd);
    send(ir_a, 30'h9, lat);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall%0d_handshake got vld=%b rdy=%b want 1/0", i, bus.out_valid, bus.in_ready); end
      n_checks++; if (bus.out_x !== ex_x || bus.out_y !== ex_y || bus.out_ir !== ir_a) begin n_fail++; $display("FAIL stall%0d_stable got %h/%h/%h want %h/%h/%h", i, bus.out_x, bus.out_y, bus.out_ir, ex_x, ex_y, ir_a); end
      @(negedge clk);
    end
    model(ir_b, ex_x, ex_y, ex_d, ex_l, nrd);
    @(posedge clk); #1;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_ir = ir_b; bus.in_pc = 30'hA;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.rd1_en !== 1'b1) begin n_fail++; $display("FAIL b2b_read got vld=%b en=%b want 0/1", bus.out_valid, bus.rd1_en); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_ir !== ir_b) begin n_fail++; $display("FAIL b2b_full got vld=%b ir=%h want 1/%h", bus.out_valid, bus.out_ir, ir_b); end
    n_checks++; if (bus.out_x !== ex_x || bus.out_y !== ex_y || bus.out_dst !== ex_d) begin n_fail++; $display("FAIL b2b_data got %h/%h/%0d want %h/%h/%0d", bus.out_x, bus.out_y, bus.out_dst, ex_x, ex_y, ex_d); end
    pop();
  endtask

  // use_rst=0 aborts the read with flush, use_rst=1 with reset.
  task automatic test_abort_read(input bit use_rst);
    resp_mode = 2; spur = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_ir = mk_r(6'h01, 5'd7, 5'd3, 5'd4); bus.in_pc = 30'h77;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.rd1_en !== 1'b1) begin n_fail++; $display("FAIL abort%0d_in_read got %b want 1", use_rst, bus.rd1_en); end
    @(posedge clk); #1;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_ir = mk_r(6'h01, 5'd1, 5'd2, 5'd3);
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
    resp_mode = 0;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort%0d_handshake got vld=%b rdy=%b want 0/1", use_rst, bus.out_valid, bus.in_ready); end
    n_checks++; if ({bus.rd1_en, bus.rd2_en} !== 2'b00) begin n_fail++; $display("FAIL abort%0d_rd_en got %b want 00", use_rst, {bus.rd1_en, bus.rd2_en}); end
    n_checks++; if (bus.out_ir !== NOP) begin n_fail++; $display("FAIL abort%0d_out_ir got %h want %h", use_rst, bus.out_ir, NOP); end
    repeat (3) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort%0d_stays_empty got %b want 0", use_rst, bus.out_valid); end
    if (!use_rst) begin
      // flush while EMPTY must also drop a presented instruction
      @(posedge clk); #1;
      flush = 1'b1; bus.in_valid = 1'b1; bus.in_ir = {6'h20, 26'h1};
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drops_input got %b want 0", bus.out_valid); end
    end
  endtask

  task automatic test_random();
    logic [31:0]      q_ir [$];
    logic [PC_W-1:0]  q_pc [$];
    logic [WIDTH-1:0] ex_x, ex_y;
    logic [4:0]       ex_d;
    logic             ex_l, stall_prev, haz;
    logic [132:0]     snap, prev;
    logic [31:0]      ir;
    int               nrd;
    resp_mode = 1; spur = 1'b1; stall_prev = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 600) begin
        bus.in_valid = ($urandom_range(0, 2) != 0);
        bus.in_ir = rand_ir(); bus.in_pc = PC_W'($urandom);
        bus.out_ready = ($urandom_range(0, 2) != 0);
        bus.ex_valid = 1'($urandom_range(0, 1)); bus.ex_load = 1'($urandom_range(0, 1));
        bus.ex_dst = 5'($urandom_range(0, 7));
      end else begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.ex_valid = 1'b0;
      end
      @(negedge clk);
      snap = {bus.out_ir, bus.out_x, bus.out_y, bus.out_pc, bus.out_dst, bus.out_load, bus.out_valid};
      if (stall_prev) begin
        n_checks++; if (snap !== prev) begin n_fail++; $display("FAIL rand_stall_stable cyc%0d got %h want %h", cyc, snap, prev); end
      end
      haz = bus.ex_valid && bus.ex_load && bus.ex_dst != 0;
      if (bus.rd1_en) begin
        n_checks++; if (bus.rd1_addr == 0 || (haz && bus.ex_dst == bus.rd1_addr)) begin n_fail++; $display("FAIL rand_rd1_request cyc%0d addr=%0d ex_dst=%0d", cyc, bus.rd1_addr, bus.ex_dst); end
      end
      if (bus.rd2_en) begin
        n_checks++; if (bus.rd2_addr == 0 || (haz && bus.ex_dst == bus.rd2_addr)) begin n_fail++; $display("FAIL rand_rd2_request cyc%0d addr=%0d ex_dst=%0d", cyc, bus.rd2_addr, bus.ex_dst); end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (q_ir.size() == 0) begin
          n_fail++; $display("FAIL rand_unexpected_output cyc%0d ir=%h want nothing", cyc, bus.out_ir);
        end else begin
          ir = q_ir.pop_front();
          model(ir, ex_x, ex_y, ex_d, ex_l, nrd);
          if (bus.out_ir !== ir || bus.out_pc !== q_pc.pop_front() || bus.out_x !== ex_x ||
              bus.out_y !== ex_y || bus.out_dst !== ex_d || bus.out_load !== ex_l) begin
            n_fail++;
            $display("FAIL rand_result cyc%0d got ir=%h x=%h y=%h dst=%0d ld=%b want ir=%h x=%h y=%h dst=%0d ld=%b",
                     cyc, bus.out_ir, bus.out_x, bus.out_y, bus.out_dst, bus.out_load, ir, ex_x, ex_y, ex_d, ex_l);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q_ir.push_back(bus.in_ir); q_pc.push_back(bus.in_pc);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev = snap;
    end
    n_checks++; if (q_ir.size() != 0) begin n_fail++; $display("FAIL rand_drain got %0d outstanding want 0", q_ir.size()); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = WIDTH'($urandom) | 32'h1;
    regs[3] = 32'h11;
    regs[4] = 32'h22;
    test_reset();
    test_rtype();
    test_load_sext();
    test_jump();
    test_decode_table();
    test_hazard();
    test_stall_b2b();
    test_abort_read(1'b0);
    test_abort_read(1'b1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
